mem_dma: RTL



---
 rtl/mem_dma_pkg.sv | 35 +++
 rtl/mem_dma_regs.sv | 114 +++++++++++
 rtl/mem_dma.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_dma_pkg.sv
// Shared definitions for the mem_dma word-copy engine: register map, CTRL bit
// positions, FSM states and the byte-lane merge helper.
package mem_dma_pkg;

    localparam logic [1:0] RegSrc  = 2'd0;
    localparam logic [1:0] RegDst  = 2'd1;
    localparam logic [1:0] RegLen  = 2'd2;
    localparam logic [1:0] RegCtrl = 2'd3;

    // START is write-only; BUSY shares bit 0 on reads
    localparam int unsigned CtrlStart = 0;
    localparam int unsigned CtrlBusy  = 0;
    localparam int unsigned CtrlDone  = 1;
    localparam int unsigned CtrlIe    = 2;
    localparam int unsigned CtrlFill  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StFin
    } state_e;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_dma_regs.sv
// Slave register port of mem_dma: SRC/DST/LEN/CTRL registers and the one-cycle ready pulse.
// Optional fill-mode bit is built only when DMA_FILL_EN is defined.
module mem_dma_regs
    import mem_dma_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             dma_sel,
    input  logic [3:0]       addr,
    input  logic [3:0]       wstrb,
    input  logic [31:0]      dma_data_i,
    output logic             dma_ready,
    output logic [31:0]      dma_data_o,
    input  logic             i_busy,
    input  logic             i_done_set,
    output logic             o_start,
    output logic [31:0]      o_src,
    output logic [31:2]      o_dst,
    output logic [LEN_W-1:0] o_len,
    output logic             o_ie,
    output logic             o_fill,
    output logic             o_done
);

    logic             r_ready;
    logic [31:0]      r_rdata;
    logic [31:0]      r_src;
    logic [31:2]      r_dst;
    logic [LEN_W-1:0] r_len;
    logic             r_ie;
    logic             r_done;

    logic             w_access;
    logic             w_wr;
    logic [1:0]       w_reg;
    logic             w_ctrl_wr;
    logic [31:0]      w_rmux;
    logic             w_unused_addr;

    // An access commits in the first cycle of dma_sel; r_ready then blocks a re-commit
    assign w_access      = dma_sel && !r_ready;
    assign w_wr          = w_access && (wstrb != 4'h0);
    assign w_reg         = addr[3:2];
    assign w_ctrl_wr     = w_wr && (w_reg == RegCtrl) && wstrb[0];
    assign w_unused_addr = ^addr[1:0];

    assign o_start = w_ctrl_wr && dma_data_i[CtrlStart] && !i_busy;

`ifdef DMA_FILL_EN
    logic r_fill;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fill <= 1'b0;
        end else if (w_ctrl_wr && !i_busy) begin
            r_fill <= dma_data_i[CtrlFill];
        end
    end

    assign o_fill = r_fill;
`else
    assign o_fill = 1'b0;
`endif

    always_comb begin
        w_rmux = '0;
        case (w_reg)
            RegSrc:  w_rmux = {r_src[31:2], 2'b00};
            RegDst:  w_rmux = {r_dst, 2'b00};
            RegLen:  w_rmux = 32'(r_len);
            default: w_rmux = {28'h0, o_fill, r_ie, r_done, i_busy};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_ie    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ready <= w_access;
            if (w_access) r_rdata <= w_rmux;
            if (w_wr && !i_busy) begin
                case (w_reg)
                    RegSrc: r_src <= apply_strb(r_src, dma_data_i, wstrb);
                    RegDst: r_dst <= 30'(apply_strb({r_dst, 2'b00}, dma_data_i, wstrb) >> 2);
                    RegLen: r_len <= LEN_W'(apply_strb(32'(r_len), dma_data_i, wstrb));
                    default: ;
                endcase
            end
            if (w_ctrl_wr) r_ie <= dma_data_i[CtrlIe];
            if (i_done_set) begin
                r_done <= 1'b1;
            end else if (w_ctrl_wr && dma_data_i[CtrlDone]) begin
                r_done <= 1'b0;
            end
        end
    end

    assign dma_ready  = r_ready && dma_sel;
    assign dma_data_o = dma_ready ? r_rdata : 32'h0;
    assign o_src      = r_src;
    assign o_dst      = r_dst;
    assign o_len      = r_len;
    assign o_ie       = r_ie;
    assign o_done     = r_done;

endmodule

// File: rtl/mem_dma.sv
// Word-copy DMA engine top: copy FSM and master-port datapath around mem_dma_regs.
// Defining DMA_FILL_EN enables fill mode (SRC value replicated to DST).
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dma_sel,
    input  logic [3:0]        addr,
    input  logic [3:0]        wstrb,
    input  logic [31:0]       dma_data_i,
    output logic              dma_ready,
    output logic [31:0]       dma_data_o,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              m_ready,
    input  logic [31:0]       m_rdata,
    output logic              dma_irq
);

    logic             w_start;
    logic [31:0]      w_src;
    logic [31:2]      w_dst;
    logic [LEN_W-1:0] w_len;
    logic             w_ie;
    logic             w_fill;
    logic             w_done;
    logic             w_busy;
    logic             w_done_set;

    state_e            r_state,     w_state_nxt;
    logic [ADDR_W-1:0] r_src_ptr,   w_src_ptr_nxt;
    logic [ADDR_W-1:0] r_dst_ptr,   w_dst_ptr_nxt;
    logic [LEN_W-1:0]  r_cnt,       w_cnt_nxt;
    logic [31:0]       r_data,      w_data_nxt;
    logic              r_m_valid,   w_m_valid_nxt;
    logic [ADDR_W-1:0] r_m_addr,    w_m_addr_nxt;
    logic [31:0]       r_m_wdata,   w_m_wdata_nxt;
    logic [3:0]        r_m_wstrb,   w_m_wstrb_nxt;

    mem_dma_regs #(
        .LEN_W (LEN_W)
    ) u_regs (
        .clk        (clk),
        .reset_n    (reset_n),
        .dma_sel    (dma_sel),
        .addr       (addr),
        .wstrb      (wstrb),
        .dma_data_i (dma_data_i),
        .dma_ready  (dma_ready),
        .dma_data_o (dma_data_o),
        .i_busy     (w_busy),
        .i_done_set (w_done_set),
        .o_start    (w_start),
        .o_src      (w_src),
        .o_dst      (w_dst),
        .o_len      (w_len),
        .o_ie       (w_ie),
        .o_fill     (w_fill),
        .o_done     (w_done)
    );

    assign w_busy     = (r_state != StIdle);
    assign w_done_set = (r_state == StFin);

    // Each phase raises m_valid one cycle after entry and drops it the cycle after m_ready
    always_comb begin
        w_state_nxt   = r_state;
        w_src_ptr_nxt = r_src_ptr;
        w_dst_ptr_nxt = r_dst_ptr;
        w_cnt_nxt     = r_cnt;
        w_data_nxt    = r_data;
        w_m_valid_nxt = r_m_valid;
        w_m_addr_nxt  = r_m_addr;
        w_m_wdata_nxt = r_m_wdata;
        w_m_wstrb_nxt = r_m_wstrb;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_src_ptr_nxt = ADDR_W'({w_src[31:2], 2'b00});
                    w_dst_ptr_nxt = ADDR_W'({w_dst, 2'b00});
                    w_cnt_nxt     = w_len;
                    w_data_nxt    = w_src;
                    if (w_len == '0) begin
                        w_state_nxt = StFin;
                    end else if (w_fill) begin
                        w_state_nxt = StWr;
                    end else begin
                        w_state_nxt = StRd;
                    end
                end
            end
            StRd: begin
                if (!r_m_valid) begin
                    w_m_valid_nxt = 1'b1;
                    w_m_addr_nxt  = r_src_ptr;
                    w_m_wdata_nxt = '0;
                    w_m_wstrb_nxt = 4'h0;
                end else if (m_ready) begin
                    w_m_valid_nxt = 1'b0;
                    w_m_addr_nxt  = '0;
                    w_data_nxt    = m_rdata;
                    w_src_ptr_nxt = r_src_ptr + ADDR_W'(4);
                    w_state_nxt   = StWr;
                end
            end
            StWr: begin
                if (!r_m_valid) begin
                    w_m_valid_nxt = 1'b1;
                    w_m_addr_nxt  = r_dst_ptr;
                    w_m_wdata_nxt = r_data;
                    w_m_wstrb_nxt = 4'hf;
                end else if (m_ready) begin
                    w_m_valid_nxt = 1'b0;
                    w_m_addr_nxt  = '0;
                    w_m_wdata_nxt = '0;
                    w_m_wstrb_nxt = 4'h0;
                    w_dst_ptr_nxt = r_dst_ptr + ADDR_W'(4);
                    w_cnt_nxt     = r_cnt - LEN_W'(1);
                    if (r_cnt == LEN_W'(1)) begin
                        w_state_nxt = StFin;
                    end else if (w_fill) begin
                        w_state_nxt = StWr;
                    end else begin
                        w_state_nxt = StRd;
                    end
                end
            end
            StFin: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_m_valid <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_wstrb <= 4'h0;
        end else begin
            r_state   <= w_state_nxt;
            r_src_ptr <= w_src_ptr_nxt;
            r_dst_ptr <= w_dst_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_data    <= w_data_nxt;
            r_m_valid <= w_m_valid_nxt;
            r_m_addr  <= w_m_addr_nxt;
            r_m_wdata <= w_m_wdata_nxt;
            r_m_wstrb <= w_m_wstrb_nxt;
        end
    end

    assign m_valid = r_m_valid;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_wstrb = r_m_wstrb;
    assign dma_irq = w_done && w_ie;

endmodule
